// File: rtl/noc_local_ni.sv
// Local-port network interface: TX packetizer (target, size, payload) and RX FIFO with sop/eop framing.
// One flit per cycle each way under valid/credit; router->IP latency 1 cycle; stalls hold data_o / refuse credit when full.
module noc_local_ni #(
    parameter int TAM_FLIT   = 16,
    parameter int METADEFLIT = 8,
    parameter int RX_DEPTH   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                send_req,
    input  logic [TAM_FLIT-1:0] send_target,
    input  logic [TAM_FLIT-1:0] send_size,
    output logic                send_busy,
    input  logic                send_valid,
    input  logic [TAM_FLIT-1:0] send_data,
    output logic                send_ready,
    output logic                rx_o,
    output logic [TAM_FLIT-1:0] data_o,
    input  logic                credit_i,
    input  logic                tx_i,
    input  logic [TAM_FLIT-1:0] data_i,
    output logic                credit_o,
    output logic                recv_valid,
    output logic [TAM_FLIT-1:0] recv_data,
    output logic                recv_sop,
    output logic                recv_eop,
    input  logic                recv_ready
);
    localparam int PW  = $clog2(RX_DEPTH);
    localparam int PW1 = PW + 1;
    localparam logic [TAM_FLIT-1:0] ONE     = TAM_FLIT'(1);
    localparam logic [PW:0]         DEPTH_C = PW1'(RX_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_HEADER, T_SIZE, T_PAYLOAD} tx_state_e;
    typedef enum logic [1:0] {R_HEADER, R_SIZE, R_PAYLOAD} rx_state_e;

    tx_state_e           tx_state_q, tx_state_d;
    logic [TAM_FLIT-1:0] target_q, target_d;
    logic [TAM_FLIT-1:0] size_q, size_d;
    logic [TAM_FLIT-1:0] count_q, count_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= T_IDLE;
            target_q   <= '0;
            size_q     <= '0;
            count_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            target_q   <= target_d;
            size_q     <= size_d;
            count_q    <= count_d;
        end
    end

    // rx_o never looks at credit_i; credit only gates the state advance.
    always_comb begin
        tx_state_d = tx_state_q;
        target_d   = target_q;
        size_d     = size_q;
        count_d    = count_q;
        rx_o       = 1'b0;
        data_o     = '0;
        send_ready = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (send_req) begin
                    tx_state_d = T_HEADER;
                    target_d   = send_target;
                    size_d     = send_size;
                    count_d    = send_size;
                end
            end
            T_HEADER: begin
                rx_o   = 1'b1;
                data_o = {target_q[TAM_FLIT-1 -: METADEFLIT], target_q[METADEFLIT-1:0]};
                if (credit_i) tx_state_d = T_SIZE;
            end
            T_SIZE: begin
                rx_o   = 1'b1;
                data_o = size_q;
                if (credit_i) tx_state_d = (size_q != '0) ? T_PAYLOAD : T_IDLE;
            end
            T_PAYLOAD: begin
                rx_o   = send_valid;
                data_o = send_data;
                if (send_valid && credit_i) begin
                    send_ready = 1'b1;
                    count_d    = count_q - ONE;
                    if (count_q == ONE) tx_state_d = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign send_busy = (tx_state_q != T_IDLE);

    logic [TAM_FLIT+1:0] mem_q [RX_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         occ_q, occ_d;
    rx_state_e           rx_state_q, rx_state_d;
    logic [TAM_FLIT-1:0] rcount_q, rcount_d;
    logic                sop_tag, eop_tag;
    logic                rx_push, rx_pop;
    logic [TAM_FLIT+1:0] head;

    // Credit comes from the registered occupancy only, so a full FIFO refuses a flit even when popping.
    assign credit_o   = reset & (occ_q != DEPTH_C);
    assign recv_valid = (occ_q != '0);
    assign rx_push    = tx_i & credit_o;
    assign rx_pop     = recv_valid & recv_ready;
    assign head       = mem_q[rd_ptr_q];
    assign recv_data  = recv_valid ? head[TAM_FLIT-1:0] : '0;
    assign recv_eop   = recv_valid & head[TAM_FLIT];
    assign recv_sop   = recv_valid & head[TAM_FLIT+1];

    always_comb begin
        rx_state_d = rx_state_q;
        rcount_d   = rcount_q;
        sop_tag    = 1'b0;
        eop_tag    = 1'b0;
        case (rx_state_q)
            R_HEADER: begin
                sop_tag = 1'b1;
                if (rx_push) rx_state_d = R_SIZE;
            end
            R_SIZE: begin
                eop_tag = (data_i == '0);
                if (rx_push) begin
                    rcount_d   = data_i;
                    rx_state_d = eop_tag ? R_HEADER : R_PAYLOAD;
                end
            end
            R_PAYLOAD: begin
                eop_tag = (rcount_q == ONE);
                if (rx_push) begin
                    rcount_d = rcount_q - ONE;
                    if (eop_tag) rx_state_d = R_HEADER;
                end
            end
            default: rx_state_d = R_HEADER;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({rx_push, rx_pop})
            2'b10:   occ_d = occ_q + PW1'(1);
            2'b01:   occ_d = occ_q - PW1'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            rx_state_q <= R_HEADER;
            rcount_q   <= '0;
        end else begin
            if (rx_push) begin
                mem_q[wr_ptr_q] <= {sop_tag, eop_tag, data_i};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (rx_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            occ_q      <= occ_d;
            rx_state_q <= rx_state_d;
            rcount_q   <= rcount_d;
        end
    end
endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed link scenarios plus randomized packets against a packet-level model.
module tb_noc_local_ni;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         send_req, send_valid, credit_i, tx_i, recv_ready;
    logic [W-1:0] send_target, send_size, send_data, data_i;
    logic         send_busy, send_ready, rx_o, credit_o, recv_valid, recv_sop, recv_eop;
    logic [W-1:0] data_o, recv_data;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] tx_got[$];
    logic [W-1:0] tx_exp[$];
    logic [W-1:0] rx_src[$];
    logic [W+1:0] rx_exp[$];

    noc_local_ni dut (
        .clock(clock), .reset(reset),
        .send_req(send_req), .send_target(send_target), .send_size(send_size),
        .send_busy(send_busy), .send_valid(send_valid), .send_data(send_data),
        .send_ready(send_ready), .rx_o(rx_o), .data_o(data_o), .credit_i(credit_i),
        .tx_i(tx_i), .data_i(data_i), .credit_o(credit_o), .recv_valid(recv_valid),
        .recv_data(recv_data), .recv_sop(recv_sop), .recv_eop(recv_eop),
        .recv_ready(recv_ready)
    );

    always #5 clock = ~clock;

    // Records every flit that will cross the TX link on the coming rising edge.
    always begin
        @(negedge clock);
        #2;
        if (reset === 1'b1 && rx_o === 1'b1 && credit_i === 1'b1) tx_got.push_back(data_o);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic test_reset;
        reset = 1'b0; send_req = 0; send_valid = 0; credit_i = 1; tx_i = 1; recv_ready = 0;
        send_target = '0; send_size = '0; send_data = '0; data_i = 16'h1234;
        #12;
        checks++;
        if ({rx_o, send_busy, send_ready, credit_o, recv_valid, recv_sop, recv_eop} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {rx_o, send_busy, send_ready, credit_o, recv_valid, recv_sop, recv_eop});
        end
        checks++;
        if (data_o !== 16'h0 || recv_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got data_o=%h recv_data=%h want 0", data_o, recv_data);
        end
        @(negedge clock);
        tx_i = 0;
        reset = 1'b1;
        #1;
        checks++;
        if (credit_o !== 1'b1 || rx_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got credit_o=%b rx_o=%b want 1 0", credit_o, rx_o);
        end
    endtask

    task automatic test_tx_basic;
        logic [W-1:0] exp [5];
        exp = '{16'h0102, 16'h0003, 16'hA0A0, 16'hB0B1, 16'hC0C2};
        @(negedge clock);
        send_req = 1; send_target = 16'h0102; send_size = 16'h0003;
        credit_i = 1; send_valid = 1; send_data = exp[2];
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            send_req = 0; send_target = 16'hFFFF; send_size = 16'h00FF;
            if (c >= 2) send_data = exp[c];
            #1;
            checks++;
            if (rx_o !== 1'b1 || data_o !== exp[c] || send_ready !== (c >= 2)) begin
                errors++;
                $display("FAIL tx_basic_flit%0d got rx_o=%b data_o=%h send_ready=%b want 1 %h %b",
                         c, rx_o, data_o, send_ready, exp[c], (c >= 2));
            end
        end
        @(negedge clock);
        send_valid = 0;
        #1;
        checks++;
        if (send_busy !== 1'b0 || rx_o !== 1'b0) begin
            errors++;
            $display("FAIL tx_basic_done got send_busy=%b rx_o=%b want 0 0", send_busy, rx_o);
        end
    endtask

    task automatic test_tx_backpressure;
        logic [W-1:0] p0, p1, ed;
        logic [W-1:0] want [4];
        logic         ev;
        p0 = 16'($urandom); p1 = 16'($urandom);
        tx_got.delete();
        @(negedge clock);
        send_req = 1; send_target = 16'h0305; send_size = 16'h0002;
        credit_i = 1; send_valid = 1; send_data = p0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            send_req   = (c == 3);
            credit_i   = !(c >= 2 && c <= 4);
            send_valid = (c != 6);
            send_data  = (c == 8) ? p1 : p0;
            #1;
            ev = 1'b1;
            case (c)
                1:       ed = 16'h0305;
                6:       begin ev = 1'b0; ed = '0; end
                7:       ed = p0;
                8:       ed = p1;
                default: ed = 16'h0002;
            endcase
            checks++;
            if (rx_o !== ev || (ev && data_o !== ed)) begin
                errors++;
                $display("FAIL tx_bp_cycle%0d got rx_o=%b data_o=%h want %b %h", c, rx_o, data_o, ev, ed);
            end
        end
        @(negedge clock);
        send_valid = 0; credit_i = 1;
        #1;
        checks++;
        if (send_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_bp_done got send_busy=%b want 0", send_busy);
        end
        want = '{16'h0305, 16'h0002, p0, p1};
        checks++;
        if (tx_got.size() != 4) begin
            errors++;
            $display("FAIL tx_bp_count got %0d want 4", tx_got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tx_got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL tx_bp_flit%0d got %h want %h", i, tx_got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_tx_size0;
        tx_got.delete();
        @(negedge clock);
        send_req = 1; send_target = 16'h0001; send_size = 16'h0000; credit_i = 1; send_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            send_req = 0;
            #1;
            checks++;
            if ((c == 1 && (rx_o !== 1'b1 || data_o !== 16'h0001)) ||
                (c == 2 && (rx_o !== 1'b1 || data_o !== 16'h0000)) ||
                (c == 3 && (rx_o !== 1'b0 || send_busy !== 1'b0))) begin
                errors++;
                $display("FAIL tx_size0_cycle%0d got rx_o=%b data_o=%h send_busy=%b", c, rx_o, data_o, send_busy);
            end
        end
        checks++;
        if (tx_got.size() != 2) begin
            errors++;
            $display("FAIL tx_size0_count got %0d want 2", tx_got.size());
        end
    endtask

    // Drives one packet with random credit/valid gaps and garbage on the request inputs mid-packet.
    task automatic tx_packet(input logic [W-1:0] tgt, input int sz, input int cpct, input int vpct);
        logic [W-1:0] pay[$];
        int pidx = 0;
        int nbusy = 0;
        tx_got.delete(); tx_exp.delete();
        tx_exp.push_back(tgt);
        tx_exp.push_back(16'(sz));
        for (int i = 0; i < sz; i++) begin
            pay.push_back(16'($urandom));
            tx_exp.push_back(pay[i]);
        end
        @(negedge clock);
        send_req = 1; send_target = tgt; send_size = 16'(sz); send_valid = 0;
        credit_i = ($urandom_range(99) < cpct);
        forever begin
            @(negedge clock);
            if (send_busy !== 1'b1 || nbusy >= 500) break;
            nbusy++;
            send_req    = 1'($urandom_range(1));
            send_target = 16'($urandom);
            send_size   = 16'($urandom);
            credit_i    = ($urandom_range(99) < cpct);
            send_valid  = ($urandom_range(99) < vpct);
            send_data   = (pidx < sz) ? pay[pidx] : 16'($urandom);
            #1;
            if (send_ready === 1'b1) pidx++;
        end
        send_req = 0; send_valid = 0;
        checks++;
        if (nbusy >= 500 || pidx != sz) begin
            errors++;
            $display("FAIL tx_pkt_consumed got %0d payload flits in %0d cycles want %0d", pidx, nbusy, sz);
        end
        if (cpct == 100 && vpct == 100) begin
            checks++;
            if (nbusy != 2 + sz) begin
                errors++;
                $display("FAIL tx_pkt_min_cost got %0d busy cycles want %0d", nbusy, 2 + sz);
            end
        end
        checks++;
        if (tx_got.size() != tx_exp.size()) begin
            errors++;
            $display("FAIL tx_pkt_count got %0d want %0d", tx_got.size(), tx_exp.size());
        end else begin
            for (int i = 0; i < tx_exp.size(); i++) begin
                checks++;
                if (tx_got[i] !== tx_exp[i]) begin
                    errors++;
                    $display("FAIL tx_pkt_flit%0d got %h want %h", i, tx_got[i], tx_exp[i]);
                end
            end
        end
    endtask

    task automatic test_tx_random;
        tx_packet(16'h0207, 4, 100, 100);
        for (int k = 0; k < 8; k++) tx_packet(16'($urandom), int'($urandom_range(6)), 60, 70);
        tx_packet(16'h0000, 0, 100, 100);
    endtask

    // Expected RX tags come straight from the packet shape: header first, size flit, then n payloads.
    task automatic add_rx_pkt(input logic [W-1:0] hdr, input int n);
        logic [W-1:0] d;
        rx_src.push_back(hdr);
        rx_exp.push_back({1'b1, 1'b0, hdr});
        rx_src.push_back(16'(n));
        rx_exp.push_back({1'b0, (n == 0), 16'(n)});
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            rx_src.push_back(d);
            rx_exp.push_back({1'b0, (i == n - 1), d});
        end
    endtask

    task automatic rx_run(input int rdy_pct, input int tx_pct);
        logic [W-1:0] cur = '0;
        logic [W+1:0] e;
        bit           cur_vld = 0;
        int           budget = 0;
        while ((rx_src.size() > 0 || cur_vld || rx_exp.size() > 0) && budget < 3000) begin
            @(negedge clock);
            budget++;
            if (!cur_vld && rx_src.size() > 0 && $urandom_range(99) < tx_pct) begin
                cur = rx_src.pop_front();
                cur_vld = 1;
            end
            tx_i = cur_vld;
            data_i = cur_vld ? cur : 16'($urandom);
            recv_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (recv_valid === 1'b1 && recv_ready) begin
                checks++;
                if (rx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rx_extra got %h want nothing", recv_data);
                end else begin
                    e = rx_exp.pop_front();
                    if ({recv_sop, recv_eop, recv_data} !== e) begin
                        errors++;
                        $display("FAIL rx_flit got sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                 recv_sop, recv_eop, recv_data, e[W+1], e[W], e[W-1:0]);
                    end
                end
            end else if (recv_valid === 1'b0) begin
                checks++;
                if ({recv_sop, recv_eop, recv_data} !== '0) begin
                    errors++;
                    $display("FAIL rx_empty_out got sop=%b eop=%b data=%h want 0", recv_sop, recv_eop, recv_data);
                end
            end
            if (tx_i && credit_o === 1'b1) cur_vld = 0;
        end
        checks++;
        if (budget >= 3000) begin
            errors++;
            $display("FAIL rx_timeout got %0d flits left want 0", rx_exp.size());
        end
        @(negedge clock);
        tx_i = 0; recv_ready = 0;
    endtask

    task automatic test_rx_full;
        rx_src.delete(); rx_exp.delete();
        add_rx_pkt(16'h0201, 2);
        add_rx_pkt(16'h0300, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            recv_ready = 0; tx_i = 1; data_i = rx_src.pop_front();
            #1;
            checks++;
            if (credit_o !== 1'b1) begin
                errors++;
                $display("FAIL rx_full_fill%0d got credit_o=%b want 1", i, credit_o);
            end
        end
        @(negedge clock);
        tx_i = 1; data_i = rx_src[0]; recv_ready = 1;
        #1;
        checks++;
        if (credit_o !== 1'b0 || {recv_valid, recv_sop, recv_eop, recv_data} !== {1'b1, rx_exp[0]}) begin
            errors++;
            $display("FAIL rx_full_state got credit_o=%b valid=%b sop=%b data=%h want 0 1 1 0201",
                     credit_o, recv_valid, recv_sop, recv_data);
        end
        void'(rx_exp.pop_front());
        @(negedge clock);
        recv_ready = 0;
        #1;
        checks++;
        if (credit_o !== 1'b1 || recv_data !== 16'h0002 || recv_sop !== 1'b0) begin
            errors++;
            $display("FAIL rx_full_after_pop got credit_o=%b data=%h sop=%b want 1 0002 0",
                     credit_o, recv_data, recv_sop);
        end
        void'(rx_src.pop_front());
        rx_run(70, 100);
    endtask

    task automatic test_rx_framing;
        rx_src.delete(); rx_exp.delete();
        add_rx_pkt(16'h0A0B, 2);
        add_rx_pkt(16'h0C0D, 0);
        @(negedge clock);
        recv_ready = 0; tx_i = 1; data_i = rx_src.pop_front();
        #1;
        checks++;
        if (recv_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_latency_before got recv_valid=%b want 0", recv_valid);
        end
        @(negedge clock);
        tx_i = 0;
        #1;
        checks++;
        if (recv_valid !== 1'b1 || recv_sop !== 1'b1 || recv_eop !== 1'b0 || recv_data !== 16'h0A0B) begin
            errors++;
            $display("FAIL rx_latency_after got valid=%b sop=%b eop=%b data=%h want 1 1 0 0a0b",
                     recv_valid, recv_sop, recv_eop, recv_data);
        end
        rx_run(100, 100);
        for (int k = 0; k < 6; k++) add_rx_pkt(16'($urandom), int'($urandom_range(5)));
        rx_run(50, 60);
    endtask

    task automatic test_async_reset;
        logic [W-1:0] p [4];
        for (int i = 0; i < 4; i++) p[i] = 16'($urandom);
        rx_src.delete(); rx_exp.delete();
        @(negedge clock);
        recv_ready = 0; tx_i = 1; data_i = 16'h0707;
        @(negedge clock);
        data_i = 16'h0003;
        @(negedge clock);
        tx_i = 0;
        send_req = 1; send_target = 16'h0909; send_size = 16'h0004;
        credit_i = 1; send_valid = 1; send_data = p[0];
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            send_req = 0;
            if (c >= 3) send_data = p[c - 3];
        end
        @(negedge clock);
        send_data = p[2];
        #1;
        checks++;
        if (rx_o !== 1'b1 || data_o !== p[2]) begin
            errors++;
            $display("FAIL rst_pre got rx_o=%b data_o=%h want 1 %h", rx_o, data_o, p[2]);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_o, send_busy, send_ready, credit_o, recv_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async got rx_o=%b busy=%b ready=%b credit_o=%b recv_valid=%b want 0",
                     rx_o, send_busy, send_ready, credit_o, recv_valid);
        end
        @(negedge clock);
        reset = 1'b1; send_valid = 0;
        #1;
        checks++;
        if (credit_o !== 1'b1 || recv_valid !== 1'b0 || send_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got credit_o=%b recv_valid=%b busy=%b want 1 0 0",
                     credit_o, recv_valid, send_busy);
        end
        tx_packet(16'h0A0A, 3, 100, 100);
        add_rx_pkt(16'h0404, 1);
        rx_run(100, 100);
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_backpressure();
        test_tx_size0();
        test_tx_random();
        test_rx_full();
        test_rx_framing();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
